fetch_unit: RTL



---
 rtl/fetch_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch stage. Holds the PC, issues one instruction
//             memory read at a time over a req/ready + rvalid handshake,
//             presents the fetched word to decode and advances to PC+4 or
//             PC+imm_ext. A misaligned next PC halts fetch until reset.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic             stall,
  output logic [WIDTH-1:0] ins,
  output logic [WIDTH-1:0] pc,
  output logic             ins_valid,
  output logic             fetch_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ins_q, ins_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] next_pc;

  // Candidate next PC: branch target or fall-through, modulo 2^WIDTH
  assign next_pc = pc_q + (pc_src ? imm_ext : WIDTH'(4));

  // Next-state logic; req/valid are derived from the next state so they leave the flops
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    err_d   = err_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          ins_d   = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    req_d   = (state_d == REQ);
    valid_d = (state_d == VALID);
  end

  // State and registered outputs; synchronous active-low reset abandons any pending response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ins_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ins       = ins_q;
  assign ins_valid = valid_q;
  assign fetch_err = err_q;

endmodule
`default_nettype wire
